// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Controller states: IDLE watches for hazards, HOLD keeps the front end frozen.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Default register-address width (32 architectural registers).
  localparam int DEF_AW = 5;

  // Largest stall length the 4-bit hold counter can express.
  localparam int MAX_LOAD_STALL = 15;

  // Index of the hardwired zero register.
  localparam int ZERO_REG_IDX = 0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count up on inc, stick at all-ones, clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard detection, multi-cycle front-end hold, branch flush and
// stall-cycle statistics for a 5-stage pipeline.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16,
  parameter int ZERO_REG   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [AW-1:0]    idex_rt,
  input  logic [AW-1:0]    ifid_rs,
  input  logic [AW-1:0]    ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             hazard_sel,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  // Out-of-range settings are clamped into 1..15 so the hold counter never wraps.
  localparam int LS = (LOAD_STALL < 1) ? 1 :
                      (LOAD_STALL > MAX_LOAD_STALL) ? MAX_LOAD_STALL : LOAD_STALL;
  localparam logic [3:0] CNT_LOAD = 4'(LS - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       zero_dst;
  logic       rs_match;
  logic       rt_match;
  logic       hz;

  // A load into the hardwired zero register never produces a real dependency.
  assign zero_dst = (ZERO_REG != 0) && (idex_rt == AW'(ZERO_REG_IDX));
  assign rs_match = (idex_rt == ifid_rs);
  assign rt_match = ifid_uses_rt && (idex_rt == ifid_rt);
  assign hz       = idex_mem_read && !zero_dst && (rs_match || rt_match);

  // State and hold-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: a taken branch aborts everything, HOLD counts down to exit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (branch_taken) begin
      state_next = IDLE;
      cnt_next   = 4'd0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (hz && (LS > 1)) begin
            state_next = HOLD;
            cnt_next   = CNT_LOAD;
          end
        end
        HOLD: begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // Output decode: reset forces defaults, branch flush beats any stall.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    hazard_sel = 1'b0;
    ifid_flush = 1'b0;
    if (rst) begin
      pc_write   = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      hazard_sel = 1'b1;
    end else if ((state_reg == HOLD) || hz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      hazard_sel = 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_write),
    .clr   (stat_clr),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: three controller instances (LOAD_STALL 1, 3 and 4)
// share one stimulus stream; expected control vectors go through a queue.
module tb_hazard_ctrl_unit;

  localparam logic [3:0] D = 4'b1100;  // {pc_write, ifid_write, hazard_sel, ifid_flush}
  localparam logic [3:0] S = 4'b0010;
  localparam logic [3:0] B = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_mem_read;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       ifid_uses_rt, branch_taken, stat_clr;
  logic [2:0] pw, iw, hs, fl;
  logic [15:0] sc1, sc3;
  logic [3:0]  sc4;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.AW(5), .LOAD_STALL(1), .CNT_W(16), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .stat_clr(stat_clr), .pc_write(pw[0]),
    .ifid_write(iw[0]), .hazard_sel(hs[0]), .ifid_flush(fl[0]), .stall_cycles(sc1));

  hazard_ctrl_unit #(.AW(5), .LOAD_STALL(3), .CNT_W(16), .ZERO_REG(1)) u3 (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .stat_clr(stat_clr), .pc_write(pw[1]),
    .ifid_write(iw[1]), .hazard_sel(hs[1]), .ifid_flush(fl[1]), .stall_cycles(sc3));

  hazard_ctrl_unit #(.AW(5), .LOAD_STALL(4), .CNT_W(4), .ZERO_REG(1)) u4 (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .stat_clr(stat_clr), .pc_write(pw[2]),
    .ifid_write(iw[2]), .hazard_sel(hs[2]), .ifid_flush(fl[2]), .stall_cycles(sc4));

  function automatic logic [3:0] ctl(input int k);
    return {pw[k], iw[k], hs[k], fl[k]};
  endfunction

  task automatic clear_inputs;
    idex_mem_read = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rt = 0; branch_taken = 0; stat_clr = 0;
  endtask

  task automatic set_hz(input logic [4:0] r);
    idex_mem_read = 1; idex_rt = r; ifid_rs = r; ifid_rt = 5'd1; ifid_uses_rt = 0;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset;
    logic [3:0] e;
    rst = 1;
    set_hz(5'd8);
    ifid_rt = 5'd8; ifid_uses_rt = 1;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(D);
      @(negedge clk);
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ctl(k) !== e) begin
          failures++;
          $display("FAIL reset_ctl dut=%0d cyc=%0d got=%b want=%b", k, c, ctl(k), e);
        end
      end
      checks++;
      if ({sc1, sc3, sc4} !== 36'd0) begin
        failures++;
        $display("FAIL reset_cnt cyc=%0d got=%0d/%0d/%0d want=0", c, sc1, sc3, sc4);
      end
      next_cycle();
    end
    clear_inputs();
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_single_cycle;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_hz(5'd8);
      idex_mem_read = (c == 0);
      exp_q.push_back((c == 0) ? S : D);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctl(0) !== e) begin
        failures++;
        $display("FAIL single_ctl cyc=%0d got=%b want=%b", c, ctl(0), e);
      end
      next_cycle();
    end
    checks++;
    if (sc1 !== 16'd1) begin
      failures++;
      $display("FAIL single_cnt got=%0d want=1", sc1);
    end
    $display("test_single_cycle done");
  endtask

  task automatic test_multi_cycle;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idex_mem_read = 1; idex_rt = 5'd9; ifid_uses_rt = 1;
      ifid_rs = (c == 0) ? 5'd3 : 5'd4;
      ifid_rt = (c == 0) ? 5'd9 : 5'd5;
      exp_q.push_back((c < 3) ? S : D);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctl(1) !== e) begin
        failures++;
        $display("FAIL multi_ctl cyc=%0d got=%b want=%b", c, ctl(1), e);
      end
      next_cycle();
    end
    checks++;
    if (sc3 !== 16'd3) begin
      failures++;
      $display("FAIL multi_cnt got=%0d want=3", sc3);
    end
    $display("test_multi_cycle done");
  endtask

  task automatic test_filtered;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idex_mem_read = 1;
      idex_rt      = (c == 0) ? 5'd0 : 5'd7;
      ifid_rs      = (c == 0) ? 5'd0 : 5'd2;
      ifid_rt      = (c == 0) ? 5'd0 : 5'd7;
      ifid_uses_rt = (c != 1);
      exp_q.push_back((c == 2) ? S : D);
      @(negedge clk);
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ctl(k) !== e) begin
          failures++;
          $display("FAIL filter_ctl dut=%0d cyc=%0d got=%b want=%b", k, c, ctl(k), e);
        end
      end
      next_cycle();
    end
    checks++;
    if (sc1 !== 16'd1) begin
      failures++;
      $display("FAIL filter_cnt got=%0d want=1", sc1);
    end
    $display("test_filtered done");
  endtask

  task automatic test_branch_abort;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      if (c == 0) set_hz(5'd6);
      branch_taken = (c == 2);
      exp_q.push_back((c < 2) ? S : (c == 2) ? B : D);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctl(2) !== e) begin
        failures++;
        $display("FAIL branch_ctl cyc=%0d got=%b want=%b", c, ctl(2), e);
      end
      next_cycle();
    end
    clear_inputs();
    checks++;
    if (sc4 !== 4'd2) begin
      failures++;
      $display("FAIL branch_cnt got=%0d want=2", sc4);
    end
    $display("test_branch_abort done");
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      if (c < 6) set_hz(5'd11);
      exp_q.push_back((c < 6) ? S : D);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctl(1) !== e) begin
        failures++;
        $display("FAIL b2b_ctl cyc=%0d got=%b want=%b", c, ctl(1), e);
      end
      next_cycle();
    end
    checks++;
    if (sc3 !== 16'd6) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d want=6", sc3);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_counter_edges;
    logic [3:0] e;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_hz(5'd12);
      exp_q.push_back(S);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctl(2) !== e) begin
        failures++;
        $display("FAIL sat_ctl cyc=%0d got=%b want=%b", c, ctl(2), e);
      end
      next_cycle();
    end
    checks++;
    if (sc4 !== 4'd15) begin
      failures++;
      $display("FAIL sat_cnt got=%0d want=15", sc4);
    end
    // clear coincides with a stalled cycle (cycle 20, IDLE with hz)
    stat_clr = 1;
    next_cycle();
    stat_clr = 0;
    checks++;
    if (sc4 !== 4'd0) begin
      failures++;
      $display("FAIL clr_cnt got=%0d want=0", sc4);
    end
    next_cycle();  // cycle 21: first HOLD cycle, counts once
    checks++;
    if (sc4 !== 4'd1) begin
      failures++;
      $display("FAIL clr_resume_cnt got=%0d want=1", sc4);
    end
    // cycle 22: still HOLD with hazard inputs removed
    clear_inputs();
    exp_q.push_back(S);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ctl(2) !== e) begin
      failures++;
      $display("FAIL hold_ignore_ctl got=%b want=%b", ctl(2), e);
    end
    #1 rst = 1;
    #1;
    exp_q.push_back(D);
    e = exp_q.pop_front();
    checks++;
    if (ctl(2) !== e || sc4 !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_hold got=%b/%0d want=%b/0", ctl(2), sc4, e);
    end
    next_cycle();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(D);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctl(2) !== e) begin
        failures++;
        $display("FAIL post_rst_ctl cyc=%0d got=%b want=%b", c, ctl(2), e);
      end
      next_cycle();
    end
    $display("test_counter_edges done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_filtered();
    test_branch_abort();
    test_back_to_back();
    test_counter_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
